// File: rtl/writeback_queue_pkg.sv
// Shared definitions for the write-back queue: write-class encodings, the
// queue entry layout and small decode helpers used by the queue and its
// hazard comparators.
package writeback_queue_pkg;

  // Write class presented on the decode write port.
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  // One in-flight register write.
  typedef struct packed {
    logic        valid;  // slot holds an in-flight instruction
    logic        done;   // result has been captured
    logic [1:0]  rw;     // write class (RW_GPR or RW_FPR once allocated)
    logic [5:0]  rd;     // destination register index
    logic [4:0]  cnt;    // cycles left before the entry may retire
    logic [31:0] data;   // captured result
  } wb_entry_t;

  // Only gpr and fpr writes occupy a slot; 2'b11 behaves like RW_NONE.
  function automatic logic is_writer(input logic [1:0] rw);
    return (rw == RW_GPR) || (rw == RW_FPR);
  endfunction

  // True when an entry of class rw targets the register file selected by
  // the operand's fp bit.
  function automatic logic class_match(input logic [1:0] rw, input logic fp);
    return ((rw == RW_GPR) && !fp) || ((rw == RW_FPR) && fp);
  endfunction

endpackage

// File: rtl/wb_hazard_cmp.sv
// Compares one source operand against every queued entry and flags a
// read-after-write hazard when any valid entry writes the same register in
// the same register file.
//
// Ports:
//   ent_valid  in  DEPTH     per-entry valid bits
//   ent_rw     in  DEPTHx2   per-entry write class
//   ent_idx    in  DEPTHx5   per-entry destination index (low 5 bits)
//   src_fp     in  1         operand selects the fpr file
//   src_idx    in  5         operand register index
//   hit        out 1         operand collides with an in-flight write
module wb_hazard_cmp
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]      ent_valid,
  input  logic [DEPTH-1:0][1:0] ent_rw,
  input  logic [DEPTH-1:0][4:0] ent_idx,
  input  logic                  src_fp,
  input  logic [4:0]            src_idx,
  output logic                  hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && class_match(ent_rw[i], src_fp) && (ent_idx[i] == src_idx)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order write-back queue feeding decode's register-file write port.
// Writing instructions are allocated a tagged slot at issue, results are
// captured by tag, and entries retire in program order (one per cycle) once
// they hold their result and their minimum wait has elapsed. Source operands
// of the issuing instruction are checked against all in-flight entries.
//
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous active-high reset
//   issue_valid  in  1      instruction issuing this cycle
//   issue_rw     in  2      write class (00 none, 01 gpr, 10 fpr, 11 none)
//   issue_rd     in  6      destination register index
//   issue_wait   in  5      minimum cycles before retire
//   issue_rs     in  7      source operand {fp, 1'bx, idx[4:0]}
//   issue_rt     in  7      source operand {fp, 1'bx, idx[4:0]}
//   issue_ready  out 1      a slot can be allocated this cycle
//   issue_tag    out TAG_W  tag given to the instruction allocated this cycle
//   hazard       out 1      issue_rs or issue_rt hits an in-flight write
//   res_valid    in  1      execution result present
//   res_tag      in  TAG_W  tag of the result
//   res_data     in  32     result value
//   rwin         out 2      write class to decode (00 when idle)
//   rdin         out 6      write index to decode
//   dtowrite     out 32     write data to decode
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [1:0]       issue_rw,
  input  logic [5:0]       issue_rd,
  input  logic [4:0]       issue_wait,
  input  logic [6:0]       issue_rs,
  input  logic [6:0]       issue_rt,
  output logic             issue_ready,
  output logic [TAG_W-1:0] issue_tag,
  output logic             hazard,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic [31:0]      res_data,
  output logic [1:0]       rwin,
  output logic [5:0]       rdin,
  output logic [31:0]      dtowrite
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [TAG_W-1:0]      head_q, head_d;
  logic [TAG_W-1:0]      tail_q, tail_d;
  logic [TAG_W:0]        count_q, count_d;
  logic [1:0]            rwin_q, rwin_d;
  logic [5:0]            rdin_q, rdin_d;
  logic [31:0]           dtowrite_q, dtowrite_d;

  wb_entry_t             head_ent;
  logic                  alloc;
  logic                  retire;

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0][1:0] ent_rw;
  logic [DEPTH-1:0][4:0] ent_idx;
  logic                  hit_rs;
  logic                  hit_rt;

  // Operand bit 5 carries no register-file meaning.
  logic                  unused_src_bits;
  assign unused_src_bits = issue_rs[5] ^ issue_rt[5];

  // A full queue refuses allocation even when the head retires this cycle.
  assign issue_ready = (count_q < FULL_CNT);
  assign issue_tag   = tail_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rwin_d     = RW_NONE;
    rdin_d     = rdin_q;
    dtowrite_d = dtowrite_q;

    head_ent = entries_q[head_q];
    alloc    = issue_valid && is_writer(issue_rw) && issue_ready;
    retire   = head_ent.valid && head_ent.done && (head_ent.cnt == 5'd0);

    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].valid && (entries_q[i].cnt != 5'd0)) begin
        entries_d[i].cnt = entries_q[i].cnt - 5'd1;
      end
      // Results for empty or already-completed slots are dropped.
      if (res_valid && (res_tag == TAG_W'(i)) && entries_q[i].valid && !entries_q[i].done) begin
        entries_d[i].done = 1'b1;
        entries_d[i].data = res_data;
      end
      if (retire && (head_q == TAG_W'(i))) begin
        entries_d[i] = '0;
      end
      // Allocation only targets a free slot, so it never collides with the
      // retiring head or a captured result.
      if (alloc && (tail_q == TAG_W'(i))) begin
        entries_d[i] = '{valid: 1'b1, done: 1'b0, rw: issue_rw, rd: issue_rd,
                         cnt: issue_wait, data: 32'd0};
      end
    end

    if (retire) begin
      head_d     = head_q + TAG_W'(1);
      rwin_d     = head_ent.rw;
      rdin_d     = head_ent.rd;
      dtowrite_d = head_ent.data;
    end
    if (alloc) begin
      tail_d = tail_q + TAG_W'(1);
    end

    case ({alloc, retire})
      2'b10:   count_d = count_q + (TAG_W + 1)'(1);
      2'b01:   count_d = count_q - (TAG_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the entry array is small and its valid bits define queue
  // occupancy, so the whole array is reset rather than only the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rwin_q     <= RW_NONE;
      rdin_q     <= '0;
      dtowrite_q <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge value of every other flop.
      entries_q  <= entries_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rwin_q     <= rwin_d;
      rdin_q     <= rdin_d;
      dtowrite_q <= dtowrite_d;
    end
  end

  assign rwin     = rwin_q;
  assign rdin     = rdin_q;
  assign dtowrite = dtowrite_q;

  // Flattened views of the entries for the hazard comparators.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries_q[i].valid;
      ent_rw[i]    = entries_q[i].rw;
      ent_idx[i]   = entries_q[i].rd[4:0];
    end
  end

  wb_hazard_cmp #(.DEPTH(DEPTH)) u_hazard_rs (
    .ent_valid (ent_valid),
    .ent_rw    (ent_rw),
    .ent_idx   (ent_idx),
    .src_fp    (issue_rs[6]),
    .src_idx   (issue_rs[4:0]),
    .hit       (hit_rs)
  );

  wb_hazard_cmp #(.DEPTH(DEPTH)) u_hazard_rt (
    .ent_valid (ent_valid),
    .ent_rw    (ent_rw),
    .ent_idx   (ent_idx),
    .src_fp    (issue_rt[6]),
    .src_idx   (issue_rt[4:0]),
    .hit       (hit_rt)
  );

  assign hazard = hit_rs | hit_rt;

endmodule
